// File: rtl/clint_wb_arbiter.sv
// Two-master Wishbone classic arbiter in front of the CLINT slave port.
// Round-robin grant at cycle boundaries, with a bus-timeout watchdog that errors a hung transfer.
module clint_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [31:0] m0_adr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [31:0] m1_adr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic [31:0] s_adr_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        ERRW = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            stb_c;
    logic            timeout_c;

    // State, grant history and watchdog counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    // Grant decision, slave-side mux and response routing
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        to_cnt_d     = '0;
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_adr_o      = '0;
        s_we_o       = 1'b0;
        s_sel_o      = '0;
        s_dat_o      = '0;
        m0_dat_o     = '0;
        m0_ack_o     = 1'b0;
        m0_err_o     = 1'b0;
        m1_dat_o     = '0;
        m1_ack_o     = 1'b0;
        m1_err_o     = 1'b0;
        stb_c        = 1'b0;
        timeout_c    = 1'b0;

        if (state_q == GNT0) begin
            s_cyc_o = m0_cyc_i;
            stb_c   = m0_stb_i;
            s_adr_o = m0_adr_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_dat_o = m0_dat_i;
        end else if (state_q == GNT1) begin
            s_cyc_o = m1_cyc_i;
            stb_c   = m1_stb_i;
            s_adr_o = m1_adr_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_dat_o = m1_dat_i;
        end
        s_stb_o = stb_c;

        // Error fires on the stb cycle that would bring the count up to the limit; ack wins a tie
        timeout_c = (TIMEOUT_CYCLES != 0) && stb_c && !s_ack_i &&
                    (to_cnt_q == TO_LIM - TO_W'(1));
        if (stb_c && !s_ack_i && !timeout_c) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
                    state_d      = GNT0;
                    last_grant_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = GNT1;
                    last_grant_d = 1'b1;
                end
            end
            GNT0: begin
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i && !timeout_c;
                m0_err_o = timeout_c;
                if (timeout_c) begin
                    state_d = ERRW;
                end else if (!m0_cyc_i) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i && !timeout_c;
                m1_err_o = timeout_c;
                if (timeout_c) begin
                    state_d = ERRW;
                end else if (!m1_cyc_i) begin
                    state_d = IDLE;
                end
            end
            ERRW: begin
                // last_grant_q still names the master whose transfer timed out
                if (last_grant_q ? !m1_cyc_i : !m0_cyc_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clint_wb_arbiter.sv
// Directed bench for clint_wb_arbiter: grant order, bursts, timeout, ack/timeout tie and reset.
module tb_clint_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] A0 = 32'h0200_BFF8;
    localparam logic [31:0] A1 = 32'h0200_4000;

    clint_wb_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are checked mid-cycle, half a period from the active edge
    task automatic nc();
        @(negedge clk);
    endtask

    task automatic to_idle();
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        nc(); nc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_i = 1; s_ack_i = 0; s_dat_i = 0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = A0; m0_we_i = 0; m0_sel_i = 4'hF; m0_dat_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_adr_i = A1; m1_we_i = 0; m1_sel_i = 4'h3; m1_dat_i = 0;
        nc(); nc();
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        #1;
        chk("rst_s_cyc", 32'(s_cyc_o), 0);
        chk("rst_s_adr", s_adr_o, 0);
        chk("rst_stale_ack", 32'(m0_ack_o), 0);
        chk("rst_m0_dat", m0_dat_o, 0);
        rst_i = 0; s_ack_i = 0;

        // Single read by m0, slave acks on the 2nd stb cycle
        nc();
        m0_cyc_i = 1; m0_stb_i = 1; #1;
        chk("rd_lat0", 32'(s_cyc_o), 0);
        nc(); #1;
        chk("rd_s_cyc", 32'(s_cyc_o), 1);
        chk("rd_s_adr", s_adr_o, A0);
        chk("rd_no_ack", 32'(m0_ack_o), 0);
        nc();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF; #1;
        chk("rd_ack", 32'(m0_ack_o), 1);
        chk("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("rd_m1_ack", 32'(m1_ack_o), 0);
        chk("rd_m1_dat", m1_dat_o, 0);
        to_idle();

        // Tie after reset: m0 first, one IDLE cycle, then m1, then m0 again
        rst_i = 1; nc(); rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        nc(); #1;
        chk("tie1_adr", s_adr_o, A0);
        s_ack_i = 1; s_dat_i = 32'h0000_0011; #1;
        chk("tie1_m0_ack", 32'(m0_ack_o), 1);
        chk("tie1_m1_ack", 32'(m1_ack_o), 0);
        nc(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        nc(); #1;
        chk("tie_idle_cyc", 32'(s_cyc_o), 0);
        nc(); #1;
        chk("tie2_cyc", 32'(s_cyc_o), 1);
        chk("tie2_adr", s_adr_o, A1);
        chk("tie2_sel", 32'(s_sel_o), 32'h3);
        s_ack_i = 1; s_dat_i = 32'h0000_0022; #1;
        chk("tie2_m1_dat", m1_dat_o, 32'h0000_0022);
        chk("tie2_m0_ack", 32'(m0_ack_o), 0);
        nc(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        nc();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        nc(); #1;
        chk("tie3_adr", s_adr_o, A0);
        to_idle();

        // m0 burst of 3 writes while m1 waits (m0 requests first)
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        nc();
        m1_cyc_i = 1; m1_stb_i = 1;
        for (int i = 0; i < 3; i++) begin
            m0_dat_i = 32'hA000_0000 + 32'(i); s_ack_i = 1; #1;
            chk("bst_s_dat", s_dat_o, 32'hA000_0000 + 32'(i));
            chk("bst_s_we", 32'(s_we_o), 1);
            chk("bst_m0_ack", 32'(m0_ack_o), 1);
            chk("bst_m1_ack", 32'(m1_ack_o), 0);
            nc();
        end
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; #1;
        chk("bst_m1_wait", 32'(m1_ack_o), 0);
        nc(); nc(); #1;
        chk("bst_m1_gnt", s_adr_o, A1);
        to_idle();

        // Slave never acks: err on the 8th stb cycle, then ERRW until m0 drops cyc
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        nc();
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("to_err", 32'(m0_err_o), (i == 8) ? 32'd1 : 32'd0);
            chk("to_m0_adr", s_adr_o, A0);
            nc();
        end
        s_ack_i = 1; #1;
        chk("errw_cyc", 32'(s_cyc_o), 0);
        chk("errw_stb", 32'(s_stb_o), 0);
        chk("errw_err", 32'(m0_err_o), 0);
        chk("errw_ack", 32'(m0_ack_o), 0);
        nc(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #1;
        chk("errw_hold", 32'(s_cyc_o), 0);
        nc(); #1;
        chk("errw_idle", 32'(s_cyc_o), 0);
        nc(); #1;
        chk("errw_m1_gnt", s_adr_o, A1);
        to_idle();

        // Ack on the 8th stb cycle wins over the timeout
        m0_cyc_i = 1; m0_stb_i = 1;
        nc();
        for (int i = 1; i <= 7; i++) begin
            #1; chk("tie_to_err", 32'(m0_err_o), 0); nc();
        end
        s_ack_i = 1; s_dat_i = 32'h0BAD_CAFE; #1;
        chk("tie_to_ack", 32'(m0_ack_o), 1);
        chk("tie_to_noerr", 32'(m0_err_o), 0);
        nc(); s_ack_i = 0; #1;
        chk("tie_to_still", 32'(s_cyc_o), 1);
        to_idle();

        // Reset mid-transfer, followed by a late slave ack
        m0_cyc_i = 1; m0_stb_i = 1;
        nc(); #1;
        chk("mid_cyc", 32'(s_cyc_o), 1);
        rst_i = 1;
        nc(); rst_i = 0; s_ack_i = 1; #1;
        chk("mid_rst_cyc", 32'(s_cyc_o), 0);
        chk("mid_rst_ack", 32'(m0_ack_o), 0);
        chk("mid_rst_err", 32'(m0_err_o), 0);
        chk("mid_rst_m1", 32'(m1_ack_o), 0);
        to_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
